// File: rtl/period_meter_pkg.sv
// Shared definitions for the tick period meter and the speed-select logic.
package period_meter_pkg;

   typedef enum logic {
      WAIT_FIRST = 1'b0,
      MEASURE    = 1'b1
   } meter_state_e;

   localparam int unsigned DEF_CNT_W    = 24;
   localparam int unsigned DEF_FAST_MAX = 2097152;

endpackage

// File: rtl/sync_edge_det.sv
// Three-flop synchroniser with rising-edge detect for slow asynchronous inputs.
module sync_edge_det (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_async_i,
   output logic rise_o
);

   logic s1_q;
   logic s2_q;
   logic s3_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= d_async_i;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/tick_period_meter.sv
// Measures the clk-cycle period of a slow asynchronous tick, classifies it
// as fast/slow and flags a stalled tick.
//
// state      | meaning
// WAIT_FIRST | no reference edge yet (after reset or a stall)
// MEASURE    | counting cycles since the last reference edge
module tick_period_meter
   import period_meter_pkg::*;
#(
   parameter int unsigned CNT_W    = DEF_CNT_W,
   parameter int unsigned FAST_MAX = DEF_FAST_MAX
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             sig_in_i,
   output logic [CNT_W-1:0] period_o,
   output logic             period_vld_o,
   output logic             fast_o,
   output logic             stalled_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             rise;
   meter_state_e     state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] period_q;
   logic             period_vld_q;
   logic             fast_q;
   logic             stalled_q;
   logic [CNT_W-1:0] cnt_d;
   logic             fast_d;

   sync_edge_det u_sync (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .d_async_i(sig_in_i),
      .rise_o   (rise)
   );

   // cnt_d wraps only at CNT_MAX, where it is never used as a period.
   assign cnt_d  = cnt_q + 1'b1;
   assign fast_d = 64'(cnt_d) <= 64'(FAST_MAX);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= WAIT_FIRST;
         cnt_q        <= '0;
         period_q     <= '0;
         period_vld_q <= 1'b0;
         fast_q       <= 1'b0;
         stalled_q    <= 1'b0;
      end else begin
         period_vld_q <= 1'b0;
         unique case (state_q)
            WAIT_FIRST: begin
               if (rise) begin
                  cnt_q   <= '0;
                  state_q <= MEASURE;
               end
            end
            MEASURE: begin
               if (rise) begin
                  cnt_q <= '0;
                  if (cnt_q != CNT_MAX) begin
                     period_q     <= cnt_d;
                     fast_q       <= fast_d;
                     period_vld_q <= 1'b1;
                     stalled_q    <= 1'b0;
                  end else begin
                     // Saturated on the same cycle: this edge only restarts the reference.
                     stalled_q <= 1'b1;
                  end
               end else if (cnt_q == CNT_MAX) begin
                  stalled_q <= 1'b1;
                  state_q   <= WAIT_FIRST;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            default: state_q <= WAIT_FIRST;
         endcase
      end
   end

   assign period_o     = period_q;
   assign period_vld_o = period_vld_q;
   assign fast_o       = fast_q;
   assign stalled_o    = stalled_q;

endmodule

// File: tb/tb_tick_period_meter.sv
// Scoreboard bench: a rise-time reference model predicts each measurement,
// a negedge monitor checks the DUT outputs against it.
module tb_tick_period_meter;

   localparam int unsigned CNT_W    = 8;
   localparam int unsigned FAST_MAX = 100;
   localparam int unsigned MAXV     = (1 << CNT_W) - 1;

   logic             clk;
   logic             rst;
   logic             sig;
   logic [CNT_W-1:0] period;
   logic             period_vld;
   logic             fast;
   logic             stalled;

   typedef struct {
      int unsigned per;
      bit          fst;
   } exp_t;

   exp_t        expq[$];
   int          n_cmp = 0;
   int          n_bad = 0;

   // reference model state
   longint      edge_n = 0;
   longint      ref_e = 0;
   bit          have_ref = 0;
   bit [2:0]    hist = '0;
   int unsigned period_m = 0;
   bit          fast_m = 0;
   bit          stalled_m = 0;

   tick_period_meter #(.CNT_W(CNT_W), .FAST_MAX(FAST_MAX)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .sig_in_i    (sig),
      .period_o    (period),
      .period_vld_o(period_vld),
      .fast_o      (fast),
      .stalled_o   (stalled)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: a rise is seen two edges after sig is first sampled high.
   // Period = edges between consecutive seen rises; a gap of MAXV+1 edges
   // without a rise is a stall.
   initial begin
      forever begin
         @(posedge clk);
         edge_n++;
         if (rst) begin
            hist      = '0;
            have_ref  = 0;
            period_m  = 0;
            fast_m    = 0;
            stalled_m = 0;
            expq.delete();
         end else begin
            if (hist[1] && !hist[2]) begin
               if (have_ref && (edge_n - ref_e) <= MAXV) begin
                  period_m  = int'(edge_n - ref_e);
                  fast_m    = (period_m <= FAST_MAX);
                  stalled_m = 0;
                  expq.push_back('{per: period_m, fst: fast_m});
               end else if (have_ref) begin
                  stalled_m = 1;
               end
               have_ref = 1;
               ref_e    = edge_n;
            end else if (have_ref && (edge_n - ref_e) == MAXV + 1) begin
               stalled_m = 1;
               have_ref  = 0;
            end
            hist = {hist[1:0], sig};
         end
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (expq.size() > 0 || period_vld) begin
            n_cmp++;
            if (expq.size() == 0) begin
               n_bad++;
               $display("FAIL vld_unexpected: period_vld=1 period=%0d, required no pulse (t=%0t)", period, $time);
            end else begin
               e = expq.pop_front();
               if (!period_vld) begin
                  n_bad++;
                  $display("FAIL vld_missing: period_vld=0, required pulse with period=%0d (t=%0t)", e.per, $time);
               end else if (period != e.per[CNT_W-1:0] || fast != e.fst) begin
                  n_bad++;
                  $display("FAIL measurement: period=%0d fast=%0b, required period=%0d fast=%0b (t=%0t)",
                           period, fast, e.per, e.fst, $time);
               end
            end
         end
         n_cmp++;
         if (stalled !== stalled_m) begin
            n_bad++;
            $display("FAIL stalled: got %0b, required %0b (t=%0t)", stalled, stalled_m, $time);
         end
         n_cmp++;
         if (period !== period_m[CNT_W-1:0] || fast !== fast_m) begin
            n_bad++;
            $display("FAIL hold: period=%0d fast=%0b, required period=%0d fast=%0b (t=%0t)",
                     period, fast, period_m, fast_m, $time);
         end
      end
   end

   task automatic pulse(input int h, input int l);
      sig = 1'b1;
      repeat (h) @(negedge clk);
      sig = 1'b0;
      repeat (l) @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int p;
      int h;
      int cat;
      rst = 1'b1;
      sig = 1'b0;
      idle(3);
      n_cmp++;
      if (period !== '0 || period_vld !== 1'b0 || fast !== 1'b0 || stalled !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_state: period=%0d vld=%0b fast=%0b stalled=%0b, required all 0",
                  period, period_vld, fast, stalled);
      end
      rst = 1'b0;
      idle(2);

      // steady period 4
      repeat (8) pulse(2, 2);

      // randomized periods: short, around the fast boundary, around saturation, stall
      for (int i = 0; i < 40; i++) begin
         cat = int'($urandom_range(0, 3));
         case (cat)
            0:       p = int'($urandom_range(2, 20));
            1:       p = int'($urandom_range(FAST_MAX - 3, FAST_MAX + 3));
            2:       p = int'($urandom_range(MAXV - 2, MAXV + 3));
            default: p = int'($urandom_range(300, 320));
         endcase
         h = int'($urandom_range(1, p - 1));
         pulse(h, p - h);
      end

      // valid measurement, then held low into a stall, then recovery
      pulse(5, 25);
      pulse(5, 25);
      sig = 1'b0;
      idle(300);
      pulse(10, 20);
      pulse(15, 25);
      pulse(15, 25);

      // rise exactly at saturation, then a 10-cycle period
      pulse(3, 3);
      pulse(1, MAXV);
      pulse(5, 5);
      pulse(5, 5);

      // minimum period, then a 1-cycle reset mid-period
      repeat (10) pulse(1, 1);
      sig = 1'b1;
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      sig = 1'b0;
      idle(1);
      repeat (10) pulse(1, 1);

      // sig already high when reset releases
      idle(5);
      sig = 1'b1;
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      pulse(3, 4);
      pulse(3, 4);
      pulse(2, 5);
      idle(10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
